// File: rtl/trigger_daq_ctrl.sv
// Trigger-to-DAQ sequencer: validates received trigger packets, starts the DAQ,
// emits a two-word event header and re-arms the receiver via busy_clear.
//
// state      | meaning
// S_IDLE     | armed, waiting for trigger
// S_WAIT_END | packet in flight, waiting for end_flag (watchdog running)
// S_DAQ      | DAQ started, waiting for daq_done (watchdog running)
// S_HDR0     | header word 0 {id, type, status, 8'hEB} offered
// S_HDR1     | header word 1 (serial) offered
// S_RELEASE  | busy_clear high to re-arm the receiver
module trigger_daq_ctrl #(
    parameter int END_TIMEOUT    = 4096,
    parameter int DAQ_TIMEOUT    = 1000000,
    parameter int TO_W           = 24,
    parameter int BUSY_CLEAR_LEN = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  my_id,
    input  logic        trigger,
    input  logic        end_flag,
    input  logic        crc_status,
    input  logic [7:0]  sub_system_id,
    input  logic [7:0]  trigger_type,
    input  logic [31:0] trigger_serial,
    output logic        busy_clear,
    output logic        daq_start,
    input  logic        daq_done,
    output logic        hdr_valid,
    input  logic        hdr_ready,
    output logic [31:0] hdr_data,
    output logic [31:0] evt_cnt,
    output logic [15:0] crc_err_cnt,
    output logic [15:0] gap_cnt,
    output logic [15:0] timeout_cnt
);

    localparam int RC_W = $clog2(BUSY_CLEAR_LEN);
    localparam logic [TO_W-1:0] END_TC   = TO_W'(END_TIMEOUT - 1);
    localparam logic [TO_W-1:0] DAQ_TC   = TO_W'(DAQ_TIMEOUT - 1);
    localparam logic [RC_W-1:0] REL_LOAD = RC_W'(BUSY_CLEAR_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_END,
        S_DAQ,
        S_HDR0,
        S_HDR1,
        S_RELEASE
    } state_t;

    state_t state, state_nxt;

    logic [TO_W-1:0] wd;
    logic [RC_W-1:0] rel_cnt;
    logic [7:0]      lat_id;
    logic [7:0]      lat_type;
    logic [31:0]     lat_serial;
    logic [31:0]     prev_serial;
    logic            have_prev;
    logic            flag_gap;
    logic            flag_daq_to;
    logic            flag_bcast;

    logic            id_match;
    logic            serial_gap;
    logic            pkt_accept;
    logic            pkt_crc_bad;
    logic            end_to_hit;
    logic            daq_to_hit;
    logic [7:0]      hdr_status;

    assign id_match   = (sub_system_id == my_id) || (sub_system_id == 8'hFF);
    assign serial_gap = have_prev && (trigger_serial != (prev_serial + 32'd1));
    assign hdr_status = {4'b0000, flag_bcast, flag_gap, flag_daq_to, 1'b1};

    always_comb begin
        state_nxt   = state;
        pkt_accept  = 1'b0;
        pkt_crc_bad = 1'b0;
        end_to_hit  = 1'b0;
        daq_to_hit  = 1'b0;
        hdr_valid   = 1'b0;
        hdr_data    = 32'd0;
        busy_clear  = 1'b0;
        case (state)
            S_IDLE: begin
                if (trigger) state_nxt = S_WAIT_END;
            end
            S_WAIT_END: begin
                // end_flag takes priority over a coincident watchdog expiry
                if (end_flag) begin
                    if (!crc_status) begin
                        pkt_crc_bad = 1'b1;
                        state_nxt   = S_RELEASE;
                    end else if (id_match) begin
                        pkt_accept = 1'b1;
                        state_nxt  = S_DAQ;
                    end else begin
                        state_nxt = S_RELEASE;
                    end
                end else if (wd == END_TC) begin
                    end_to_hit = 1'b1;
                    state_nxt  = S_RELEASE;
                end
            end
            S_DAQ: begin
                if (daq_done) begin
                    state_nxt = S_HDR0;
                end else if (wd == DAQ_TC) begin
                    daq_to_hit = 1'b1;
                    state_nxt  = S_HDR0;
                end
            end
            S_HDR0: begin
                hdr_valid = 1'b1;
                hdr_data  = {lat_id, lat_type, hdr_status, 8'hEB};
                if (hdr_ready) state_nxt = S_HDR1;
            end
            S_HDR1: begin
                hdr_valid = 1'b1;
                hdr_data  = lat_serial;
                if (hdr_ready) state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                busy_clear = 1'b1;
                if (rel_cnt == '0) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            wd          <= '0;
            rel_cnt     <= '0;
            lat_id      <= 8'd0;
            lat_type    <= 8'd0;
            lat_serial  <= 32'd0;
            prev_serial <= 32'd0;
            have_prev   <= 1'b0;
            flag_gap    <= 1'b0;
            flag_daq_to <= 1'b0;
            flag_bcast  <= 1'b0;
            daq_start   <= 1'b0;
            evt_cnt     <= 32'd0;
            crc_err_cnt <= 16'd0;
            gap_cnt     <= 16'd0;
            timeout_cnt <= 16'd0;
        end else begin
            state     <= state_nxt;
            daq_start <= pkt_accept;

            // watchdog restarts on every state change and runs only while waiting
            if (state_nxt != state) begin
                wd <= '0;
            end else if (state == S_WAIT_END || state == S_DAQ) begin
                wd <= wd + TO_W'(1);
            end

            if (state_nxt == S_RELEASE && state != S_RELEASE) begin
                rel_cnt <= REL_LOAD;
            end else if (state == S_RELEASE && rel_cnt != '0) begin
                rel_cnt <= rel_cnt - RC_W'(1);
            end

            if (state == S_WAIT_END && end_flag) begin
                lat_id     <= sub_system_id;
                lat_type   <= trigger_type;
                lat_serial <= trigger_serial;
            end

            if (pkt_accept) begin
                evt_cnt     <= evt_cnt + 32'd1;
                flag_bcast  <= (sub_system_id == 8'hFF);
                prev_serial <= trigger_serial;
                have_prev   <= 1'b1;
                if (serial_gap) begin
                    flag_gap <= 1'b1;
                    if (gap_cnt != 16'hFFFF) gap_cnt <= gap_cnt + 16'd1;
                end
            end

            if (pkt_crc_bad && crc_err_cnt != 16'hFFFF) begin
                crc_err_cnt <= crc_err_cnt + 16'd1;
            end

            if ((end_to_hit || daq_to_hit) && timeout_cnt != 16'hFFFF) begin
                timeout_cnt <= timeout_cnt + 16'd1;
            end

            if (daq_to_hit) flag_daq_to <= 1'b1;

            if (state_nxt == S_IDLE && state != S_IDLE) begin
                flag_gap    <= 1'b0;
                flag_daq_to <= 1'b0;
                flag_bcast  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_trigger_daq_ctrl.sv
// Randomized bench for trigger_daq_ctrl: packet-level reference model of
// acceptance, header contents, timeouts and counters.
`timescale 1ns/1ps
module tb_trigger_daq_ctrl;

    localparam int END_TO = 40;
    localparam int DAQ_TO = 16;
    localparam int BCL    = 4;
    localparam int NEVER  = 1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  my_id = 8'h03;
    logic        trigger = 1'b0;
    logic        end_flag = 1'b0;
    logic        crc_status = 1'b0;
    logic [7:0]  sub_system_id = 8'd0;
    logic [7:0]  trigger_type = 8'd0;
    logic [31:0] trigger_serial = 32'd0;
    logic        busy_clear;
    logic        daq_start;
    logic        daq_done = 1'b0;
    logic        hdr_valid;
    logic        hdr_ready = 1'b0;
    logic [31:0] hdr_data;
    logic [31:0] evt_cnt;
    logic [15:0] crc_err_cnt;
    logic [15:0] gap_cnt;
    logic [15:0] timeout_cnt;

    trigger_daq_ctrl #(
        .END_TIMEOUT   (END_TO),
        .DAQ_TIMEOUT   (DAQ_TO),
        .TO_W          (24),
        .BUSY_CLEAR_LEN(BCL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .my_id         (my_id),
        .trigger       (trigger),
        .end_flag      (end_flag),
        .crc_status    (crc_status),
        .sub_system_id (sub_system_id),
        .trigger_type  (trigger_type),
        .trigger_serial(trigger_serial),
        .busy_clear    (busy_clear),
        .daq_start     (daq_start),
        .daq_done      (daq_done),
        .hdr_valid     (hdr_valid),
        .hdr_ready     (hdr_ready),
        .hdr_data      (hdr_data),
        .evt_cnt       (evt_cnt),
        .crc_err_cnt   (crc_err_cnt),
        .gap_cnt       (gap_cnt),
        .timeout_cnt   (timeout_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // observation of DUT outputs, sampled on the falling edge
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          ds_cnt = 0, ds_cyc = 0, hv_rise_cyc = 0, bc_rise_cyc = 0;
    int          bc_run = 0, bc_runs = 0, bc_last_len = 0;
    int          stab_viol = 0, drop_viol = 0;
    logic [31:0] hdr_q[$];
    logic        pv = 1'b0, pr = 1'b0, prst = 1'b0;
    logic [31:0] pd = 32'd0;

    always @(negedge clk) begin
        if (daq_start) begin
            ds_cnt++;
            ds_cyc = cyc;
        end
        if (hdr_valid && !pv) hv_rise_cyc = cyc;
        if (pv && !pr && !prst) begin
            if (!hdr_valid) drop_viol++;
            else if (hdr_data != pd) stab_viol++;
        end
        if (hdr_valid && hdr_ready && !reset) hdr_q.push_back(hdr_data);
        if (busy_clear) begin
            if (bc_run == 0) bc_rise_cyc = cyc;
            bc_run++;
        end else if (bc_run > 0) begin
            bc_runs++;
            bc_last_len = bc_run;
            bc_run = 0;
        end
        pv   = hdr_valid;
        pr   = hdr_ready;
        pd   = hdr_data;
        prst = reset;
    end

    int rdy_mode = 1;
    initial forever begin
        @(posedge clk);
        #1;
        hdr_ready = (rdy_mode == 1) ? ($urandom_range(0, 99) < 60) : 1'b0;
    end

    // reference model state
    logic [31:0] m_evt = 32'd0;
    logic [15:0] m_crc = 16'd0, m_gap = 16'd0, m_to = 16'd0;
    logic        m_have = 1'b0;
    logic [31:0] m_prev = 32'd0;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_counters(input string pfx);
        chk({pfx, "evt_cnt"}, evt_cnt, m_evt);
        chk({pfx, "crc_err_cnt"}, 32'(crc_err_cnt), 32'(m_crc));
        chk({pfx, "gap_cnt"}, 32'(gap_cnt), 32'(m_gap));
        chk({pfx, "timeout_cnt"}, 32'(timeout_cnt), 32'(m_to));
    endtask

    // end_dly: cycles from trigger to end_flag (> END_TO means it never comes)
    // done_dly: cycles from daq_start to daq_done (NEVER means never)
    task automatic run_pkt(input logic [7:0] id, input logic [7:0] typ, input logic [31:0] ser,
                           input logic crc, input int end_dly, input int done_dly);
        int          n_bc0, n_hdr0, n_ds0, trig_cyc, end_cyc, guard;
        logic        arrives, accepted, bcast, gap, to;
        logic [31:0] nxt, w0;
        arrives  = (end_dly <= END_TO);
        accepted = arrives && crc && (id == my_id || id == 8'hFF);
        n_bc0    = bc_runs;
        n_hdr0   = hdr_q.size();
        n_ds0    = ds_cnt;
        end_cyc  = 0;
        if ($urandom_range(0, 3) == 0) begin
            end_flag = 1'b1; crc_status = 1'b1; sub_system_id = my_id;
            step();
            end_flag = 1'b0;
        end
        trigger = 1'b1;
        trig_cyc = cyc;
        step();
        trigger = 1'b0;
        for (int i = 1; i < end_dly && i <= END_TO; i++) begin
            trigger = (i < END_TO - 1) && ($urandom_range(0, 7) == 0);
            step();
        end
        trigger = 1'b0;
        if (arrives) begin
            end_flag = 1'b1; crc_status = crc; sub_system_id = id;
            trigger_type = typ; trigger_serial = ser;
            end_cyc = cyc;
            step();
            end_flag = 1'b0;
            crc_status = 1'($urandom_range(0, 1));
            sub_system_id = 8'($urandom);
            trigger_type = 8'($urandom);
            trigger_serial = $urandom;
            if (accepted && done_dly < NEVER) begin
                repeat (done_dly) step();
                daq_done = 1'b1;
                step();
                daq_done = 1'b0;
            end
        end
        guard = 0;
        while (bc_runs == n_bc0 && guard < 400) begin
            trigger = hdr_valid && ($urandom_range(0, 3) == 0);
            step();
            guard++;
        end
        trigger = 1'b0;
        chk("busy_clear_seen", 32'(guard < 400), 32'd1);

        if (!arrives) m_to = sat_inc(m_to);
        else if (!crc) m_crc = sat_inc(m_crc);
        if (accepted) begin
            nxt   = m_prev + 32'd1;
            bcast = (id == 8'hFF);
            gap   = m_have && (ser != nxt);
            to    = (done_dly >= DAQ_TO);
            m_evt = m_evt + 32'd1;
            if (gap) m_gap = sat_inc(m_gap);
            if (to) m_to = sat_inc(m_to);
            m_prev = ser;
            m_have = 1'b1;
            w0 = {id, typ, 4'b0000, bcast, gap, to, 1'b1, 8'hEB};
            chk("hdr_word_count", 32'(hdr_q.size() - n_hdr0), 32'd2);
            if (hdr_q.size() - n_hdr0 >= 2) begin
                chk("hdr_word0", hdr_q[n_hdr0], w0);
                chk("hdr_word1", hdr_q[n_hdr0 + 1], ser);
            end
            chk("daq_start_latency", 32'(ds_cyc - end_cyc), 32'd1);
            chk("hdr_latency", 32'(hv_rise_cyc - ds_cyc), to ? 32'(DAQ_TO) : 32'(done_dly + 1));
        end else begin
            chk("hdr_word_count", 32'(hdr_q.size() - n_hdr0), 32'd0);
        end
        chk("daq_start_pulses", 32'(ds_cnt - n_ds0), 32'(accepted));
        chk("busy_clear_len", 32'(bc_last_len), 32'(BCL));
        if (!arrives) chk("end_timeout_latency", 32'(bc_rise_cyc - trig_cyc), 32'(END_TO + 1));
        chk("hdr_handshake_rules", 32'(stab_viol + drop_viol), 32'd0);
        chk_counters("");
        step();
        step();
    endtask

    task automatic reset_mid_hdr();
        int          guard, n_bc0, n_hdr0;
        logic [31:0] w0;
        rdy_mode = 0;
        step();
        step();
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        step();
        end_flag = 1'b1; crc_status = 1'b1; sub_system_id = my_id;
        trigger_type = 8'h5A; trigger_serial = m_prev + 32'd1;
        step();
        end_flag = 1'b0;
        daq_done = 1'b1;
        step();
        daq_done = 1'b0;
        guard = 0;
        while (!hdr_valid && guard < 20) begin
            step();
            guard++;
        end
        chk("rst_reach_hdr", 32'(hdr_valid), 32'd1);
        repeat (20) step();
        w0 = {my_id, 8'h5A, 8'h01, 8'hEB};
        chk("rst_held_valid", 32'(hdr_valid), 32'd1);
        chk("rst_held_word", hdr_data, w0);
        chk("rst_hold_stable", 32'(stab_viol + drop_viol), 32'd0);
        n_bc0  = bc_runs;
        n_hdr0 = hdr_q.size();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_busy_clear", 32'(busy_clear), 32'd0);
        chk("rst_daq_start", 32'(daq_start), 32'd0);
        chk("rst_hdr_valid", 32'(hdr_valid), 32'd0);
        chk("rst_hdr_data", hdr_data, 32'd0);
        m_evt = 32'd0; m_crc = 16'd0; m_gap = 16'd0; m_to = 16'd0;
        m_have = 1'b0; m_prev = 32'd0;
        chk_counters("rst_");
        rdy_mode = 1;
        repeat (10) step();
        chk("rst_no_busy_clear", 32'(bc_runs - n_bc0 + bc_run), 32'd0);
        chk("rst_no_hdr_word", 32'(hdr_q.size() - n_hdr0), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        logic [7:0]  rid;
        logic [31:0] rser;
        int          sel, edly, ddly;
        reset = 1'b1;
        repeat (3) step();
        chk("reset_busy_clear", 32'(busy_clear), 32'd0);
        chk("reset_daq_start", 32'(daq_start), 32'd0);
        chk("reset_hdr_valid", 32'(hdr_valid), 32'd0);
        chk("reset_hdr_data", hdr_data, 32'd0);
        chk_counters("reset_");
        reset = 1'b0;
        step();

        run_pkt(8'h03, 8'h01, 32'd5, 1'b1, 3, 10);
        run_pkt(8'h03, 8'h02, 32'd6, 1'b0, 4, 0);
        run_pkt(8'h03, 8'h01, 32'hFFFF_FFFF, 1'b1, 2, 1);
        run_pkt(8'h03, 8'h01, 32'h0000_0000, 1'b1, 5, 2);
        run_pkt(8'h03, 8'h01, 32'h0000_0002, 1'b1, 1, 3);
        run_pkt(8'hFF, 8'h04, 32'd3, 1'b1, 6, 4);
        run_pkt(8'h07, 8'h04, 32'd4, 1'b1, 2, 0);
        run_pkt(8'h03, 8'h09, 32'd4, 1'b1, 3, NEVER);
        run_pkt(8'h03, 8'h09, 32'd5, 1'b1, NEVER, 0);
        run_pkt(8'h03, 8'h06, 32'd5, 1'b1, END_TO, DAQ_TO - 1);
        run_pkt(8'h03, 8'h06, 32'd6, 1'b1, END_TO + 1, 0);
        run_pkt(8'h03, 8'h06, 32'd6, 1'b1, 2, DAQ_TO);
        reset_mid_hdr();

        for (int n = 0; n < 30; n++) begin
            if (n % 8 == 7) my_id = 8'($urandom_range(0, 254));
            sel = $urandom_range(0, 3);
            rid = (sel < 2) ? my_id : (sel == 2) ? 8'hFF : 8'($urandom);
            rser = ($urandom_range(0, 3) == 0) ? $urandom : m_prev + 32'd1;
            edly = ($urandom_range(0, 4) == 0) ? $urandom_range(END_TO - 2, END_TO + 2)
                                               : $urandom_range(1, 8);
            ddly = ($urandom_range(0, 4) == 0) ? $urandom_range(DAQ_TO - 2, DAQ_TO + 1)
                                               : $urandom_range(0, 6);
            run_pkt(rid, 8'($urandom), rser, ($urandom_range(0, 7) != 0), edly, ddly);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
